// File: rtl/regs_bank_writer.sv
// Register bank feeding the selector's wRegs operand: row stores from r0..r3 and a multi-cycle bank clear.
// Optional feature macro: REGS_AUTO_ROW_EN (stores go to wWrPtr+1 instead of wRow).
module regs_bank_writer #(
  parameter int DATA_WIDTH      = 4,
  parameter int REGS_INPUTS     = 64,
  parameter int OUTPUTS         = 4,
  parameter int OUTPUTS_PER_BUS = 4,
  parameter int BUS_W           = OUTPUTS_PER_BUS * DATA_WIDTH,
  parameter int ROW_W           = OUTPUTS * BUS_W,
  parameter int ROWS            = REGS_INPUTS * DATA_WIDTH / ROW_W,
  parameter int RW              = $clog2(ROWS)
) (
  input  logic                              wClk,
  input  logic                              wResetN,
  input  logic                              wStore,
  input  logic                              wClear,
  input  logic [RW-1:0]                     wRow,
  input  logic [BUS_W-1:0]                  r0,
  input  logic [BUS_W-1:0]                  r1,
  input  logic [BUS_W-1:0]                  r2,
  input  logic [BUS_W-1:0]                  r3,
  output logic [REGS_INPUTS*DATA_WIDTH-1:0] wRegs,
  output logic                              wBusy,
  output logic                              wDone,
  output logic [RW-1:0]                     wWrPtr,
  output logic                              wStateDbg
);

  // Handshake: wStore/wClear are single-cycle requests sampled at every edge;
  // they are accepted only in IDLE and silently dropped while wBusy is high.

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t            state;
  logic [RW-1:0]     cnt;
  logic [ROW_W-1:0]  rowData;
  logic [RW-1:0]     storeRow;

  assign rowData = {r3, r2, r1, r0};

`ifdef REGS_AUTO_ROW_EN
  assign storeRow = (wWrPtr == RW'(ROWS - 1)) ? '0 : wWrPtr + 1'b1;
`else
  assign storeRow = wRow;
`endif

  assign wStateDbg = (state == CLEAR);

  always_ff @(posedge wClk or negedge wResetN) begin
    if (!wResetN) begin
      state  <= IDLE;
      cnt    <= '0;
      wRegs  <= '0;
      wBusy  <= 1'b0;
      wDone  <= 1'b0;
      wWrPtr <= '0;
    end else begin
      case (state)
        IDLE: begin
          wDone <= 1'b0;
          if (wClear) begin
            // Clear wins over a simultaneous store.
            state <= CLEAR;
            cnt   <= '0;
            wBusy <= 1'b1;
            wDone <= (ROWS == 1);
          end else if (wStore) begin
            wRegs[storeRow*ROW_W +: ROW_W] <= rowData;
            wWrPtr                         <= storeRow;
          end
        end
        CLEAR: begin
          wRegs[cnt*ROW_W +: ROW_W] <= '0;
          if (cnt == RW'(ROWS - 1)) begin
            state <= IDLE;
            wBusy <= 1'b0;
            wDone <= 1'b0;
`ifdef REGS_AUTO_ROW_EN
            wWrPtr <= RW'(ROWS - 1);
`endif
          end else begin
            cnt   <= cnt + 1'b1;
            // wDone is registered, so raise it one edge ahead of the last row.
            wDone <= (cnt == RW'(ROWS - 2));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regs_bank_writer.sv
// Randomized self-checking bench for regs_bank_writer against a row-array reference model.
module tb_regs_bank_writer;

  localparam int ROWS = 4;

  logic         wClk = 1'b0;
  logic         wResetN;
  logic         wStore;
  logic         wClear;
  logic [1:0]   wRow;
  logic [15:0]  r0, r1, r2, r3;
  logic [255:0] wRegs;
  logic         wBusy;
  logic         wDone;
  logic [1:0]   wWrPtr;
  logic         wStateDbg;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the bank as an array of rows plus "clear cycles remaining".
  logic [63:0] m_rows[ROWS];
  int          m_clear_left;
  int          m_ptr;

  regs_bank_writer dut (
    .wClk(wClk), .wResetN(wResetN), .wStore(wStore), .wClear(wClear), .wRow(wRow),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3),
    .wRegs(wRegs), .wBusy(wBusy), .wDone(wDone), .wWrPtr(wWrPtr), .wStateDbg(wStateDbg)
  );

  // clock / reset
  always #5 wClk = ~wClk;

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [255:0] m_pack();
    logic [255:0] v;
    v = '0;
    for (int k = 0; k < ROWS; k++) v[k*64 +: 64] = m_rows[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < ROWS; k++) m_rows[k] = '0;
    m_clear_left = 0;
    m_ptr        = 0;
  endtask

  task automatic model_step(input logic st, input logic cl, input int row, input logic [63:0] d);
    int target;
    if (m_clear_left > 0) begin
      m_rows[ROWS - m_clear_left] = '0;
      m_clear_left--;
`ifdef REGS_AUTO_ROW_EN
      if (m_clear_left == 0) m_ptr = ROWS - 1;
`endif
    end else if (cl) begin
      m_clear_left = ROWS;
    end else if (st) begin
`ifdef REGS_AUTO_ROW_EN
      target = (m_ptr + 1) % ROWS;
`else
      target = row;
`endif
      m_rows[target] = d;
      m_ptr = target;
    end
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, "_regs"},  wRegs, m_pack());
    check_val({tag, "_busy"},  256'(wBusy), 256'(m_clear_left > 0));
    check_val({tag, "_done"},  256'(wDone), 256'(m_clear_left == 1));
    check_val({tag, "_ptr"},   256'(wWrPtr), 256'(m_ptr));
    check_val({tag, "_state"}, 256'(wStateDbg), 256'(m_clear_left > 0));
  endtask

  // driver: one clock cycle of requests, then compare against the model
  task automatic do_cycle(input logic st, input logic cl, input logic [1:0] row,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] d, input string tag);
    @(negedge wClk);
    wStore = st; wClear = cl; wRow = row;
    r0 = a; r1 = b; r2 = c; r3 = d;
    @(posedge wClk);
    model_step(st, cl, int'(row), {d, c, b, a});
    #1;
    check_outputs(tag);
  endtask

  task automatic idle_cycle(input string tag);
    do_cycle(1'b0, 1'b0, 2'd0, 16'h0, 16'h0, 16'h0, 16'h0, tag);
  endtask

  initial begin
    wResetN = 1'b0; wStore = 1'b0; wClear = 1'b0; wRow = '0;
    r0 = '0; r1 = '0; r2 = '0; r3 = '0;
    model_reset();
    repeat (3) @(posedge wClk);
    #1;
    check_outputs("reset");
    @(negedge wClk);
    wResetN = 1'b1;

`ifndef REGS_AUTO_ROW_EN
    // store to row 2 with 1-cycle latency
    do_cycle(1'b1, 1'b0, 2'd2, 16'h1234, 16'h5678, 16'h9abc, 16'hdef0, "store2");
    check_val("store2_row", 256'(wRegs[191:128]), 256'(64'hdef09abc56781234));
    idle_cycle("store2_hold");
`else
    // auto row: five stores land in rows 1,2,3,0,1
    for (int i = 0; i < 5; i++)
      do_cycle(1'b1, 1'b0, 2'($urandom_range(0, 3)), 16'(16'ha0 + i), 16'(i), 16'h0, 16'h0, "auto");
    check_val("auto_ptr", 256'(wWrPtr), 256'(1));
    check_val("auto_row1", 256'(wRegs[127:64]), 256'(64'h0000_0000_0004_00a4));
`endif

    // fill every row, clear, and try to store during the clear
    for (int k = 0; k < ROWS; k++)
      do_cycle(1'b1, 1'b0, 2'(k), 16'hffff, 16'hffff, 16'hffff, 16'hffff, "fill");
    check_val("fill_all", wRegs, {256{1'b1}});
    do_cycle(1'b0, 1'b1, 2'd0, 16'h0, 16'h0, 16'h0, 16'h0, "clr_start");
    for (int k = 0; k < ROWS; k++)
      do_cycle(1'b1, 1'b0, 2'(k), 16'h5555, 16'haaaa, 16'h1111, 16'h2222, "clr_busy");
    check_val("clr_zero", wRegs, 256'(0));
    idle_cycle("clr_after");

    // store and clear in the same cycle: clear wins
    do_cycle(1'b1, 1'b1, 2'd1, 16'hbeef, 16'hcafe, 16'hf00d, 16'hd00d, "simul");
    repeat (ROWS + 1) idle_cycle("simul_run");
    check_val("simul_zero", wRegs, 256'(0));

    // reset in the middle of a clear
    do_cycle(1'b1, 1'b0, 2'd3, 16'h1, 16'h2, 16'h3, 16'h4, "pre_mid");
    do_cycle(1'b0, 1'b1, 2'd0, 16'h0, 16'h0, 16'h0, 16'h0, "mid_start");
    idle_cycle("mid_c1");
    @(negedge wClk);
    wResetN = 1'b0;
    #1;
    model_reset();
    check_outputs("mid_reset");
    @(negedge wClk);
    wResetN = 1'b1;
    idle_cycle("mid_release");

    // randomized traffic
    for (int i = 0; i < 400; i++)
      do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)),
               16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), "rand");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
